// File: rtl/imm_extend_stage.sv
// -----------------------------------------------------------------------------
// imm_extend_stage
//
// Registered immediate-extension stage sitting between decode and execute.
// An IN_W-bit immediate is widened to OUT_W bits in one of four modes
// (sign, zero, upper/LUI, sign-extend-and-shift for branch offsets) and passed
// downstream over a valid/ready handshake. A two-entry skid buffer (main
// output register plus one skid register) absorbs execute-stage stalls, so
// immediates are never dropped, duplicated or reordered. in_ready is a pure
// register output and has no combinational path from out_ready.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   flush     synchronous flush; drops held entries and any input this cycle
//   in_valid  in_data/in_mode are valid
//   in_ready  stage can accept an input this cycle
//   in_data   raw IN_W-bit immediate field
//   in_mode   0 = sign, 1 = zero, 2 = upper, 3 = sign-extend then shift
//   out_valid out_data is valid
//   out_ready downstream accepts out_data this cycle
//   out_data  OUT_W-bit extended immediate
// -----------------------------------------------------------------------------
module imm_extend_stage #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);

    // Reject illegal parameter combinations while elaborating.
    generate
        if (IN_W < 1 || IN_W >= OUT_W || SHIFT < 0 || SHIFT >= OUT_W) begin : g_bad_params
            $error("imm_extend_stage: need 1 <= IN_W < OUT_W and 0 <= SHIFT < OUT_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        MODE_SIGN  = 2'd0,
        MODE_ZERO  = 2'd1,
        MODE_UPPER = 2'd2,
        MODE_SHIFT = 2'd3
    } mode_e;

    localparam int PAD_W = OUT_W - IN_W;

    // Pure wiring: replication and a constant shift, no arithmetic.
    function automatic logic [OUT_W-1:0] ext(input logic [IN_W-1:0] d, input mode_e m);
        logic [OUT_W-1:0] sext;
        sext = {{PAD_W{d[IN_W-1]}}, d};
        unique case (m)
            MODE_SIGN:  ext = sext;
            MODE_ZERO:  ext = {{PAD_W{1'b0}}, d};
            MODE_UPPER: ext = {d, {PAD_W{1'b0}}};
            MODE_SHIFT: ext = sext << SHIFT;
            default:    ext = sext;
        endcase
    endfunction

    logic             skid_valid;
    logic [OUT_W-1:0] skid_data;

    logic             out_valid_d;
    logic [OUT_W-1:0] out_data_d;
    logic             skid_valid_d;
    logic [OUT_W-1:0] skid_data_d;

    logic             acc;
    logic             drain;
    logic [OUT_W-1:0] ext_in;

    assign acc    = in_valid & in_ready;
    assign drain  = ~out_valid | out_ready;
    assign ext_in = ext(in_data, mode_e'(in_mode));

    // Next-state selection. When the skid holds data, in_ready is low, so
    // no new item can arrive in the same cycle the skid drains into main.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path leaves a value unassigned and a latch cannot be inferred.
        out_valid_d  = out_valid;
        out_data_d   = out_data;
        skid_valid_d = skid_valid;
        skid_data_d  = skid_data;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain) begin
            if (skid_valid) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data;
                skid_valid_d = 1'b0;
            end else if (acc) begin
                out_valid_d = 1'b1;
                out_data_d  = ext_in;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (acc) begin
            // Main is stalled and full: park the new item in the skid.
            skid_valid_d = 1'b1;
            skid_data_d  = ext_in;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data registers are reset as well so out_data reads 0
            // straight out of reset rather than an unknown value.
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            in_ready   <= 1'b0;
        end else begin
            out_valid  <= out_valid_d;
            out_data   <= out_data_d;
            skid_valid <= skid_valid_d;
            skid_data  <= skid_data_d;
            // Mirrors the next skid state, so in_ready is registered yet
            // always equals !skid_valid after the first post-reset edge.
            in_ready   <= ~skid_valid_d;
        end
    end

endmodule

// File: tb/tb_imm_extend_stage.sv
// -----------------------------------------------------------------------------
// tb_imm_extend_stage
//
// Self-checking bench for imm_extend_stage. A behavioural model (an item queue
// plus an arithmetic extension function) predicts out_valid, out_data and
// in_ready every cycle. A second instance exercises a different parameter set.
// -----------------------------------------------------------------------------
module tb_imm_extend_stage;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
    localparam int SHIFT = 2;

    logic clk;
    logic rst_n;

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic [1:0]        in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;

    logic              b_flush;
    logic              b_in_valid;
    logic              b_in_ready;
    logic [11:0]       b_in_data;
    logic [1:0]        b_in_mode;
    logic              b_out_valid;
    logic              b_out_ready;
    logic [19:0]       b_out_data;

    imm_extend_stage #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    imm_extend_stage #(.IN_W(12), .OUT_W(20), .SHIFT(1)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (b_flush),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_mode   (b_in_mode),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    longint unsigned mq[$];   // items held by the stage, oldest first
    longint unsigned got[$];  // items the downstream consumed
    bit              fresh;   // first cycle after reset release

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Extension computed numerically: the immediate as a signed/unsigned
    // integer, scaled by a power of two, reduced modulo 2^out_w.
    function automatic longint unsigned ref_ext(input longint unsigned d, input int m,
                                                input int in_w, input int out_w, input int sh);
        longint sval;
        longint r;
        if (d >= (64'd1 << (in_w - 1))) sval = longint'(d) - longint'(64'd1 << in_w);
        else                            sval = longint'(d);
        case (m)
            0:       r = sval;
            1:       r = longint'(d);
            2:       r = longint'(d) * longint'(64'd1 << (out_w - in_w));
            default: r = sval * longint'(64'd1 << sh);
        endcase
        return longint'(r) & ((64'd1 << out_w) - 64'd1);
    endfunction

    // One clock cycle on the main instance. Called at a negedge with inputs
    // already driven; compares outputs to the model, then advances the model.
    task automatic step(output bit accepted);
        bit exp_ready;
        bit consumed;
        exp_ready = !fresh && (mq.size() < 2);
        check("out_valid", out_valid, mq.size() != 0);
        if (mq.size() != 0) check("out_data", out_data, mq[0]);
        check("in_ready", in_ready, exp_ready);
        consumed = (mq.size() != 0) && out_ready;
        accepted = in_valid && exp_ready && !flush;
        if (consumed && !flush) got.push_back(longint'(out_data));
        @(posedge clk);
        fresh = 1'b0;
        if (flush) begin
            mq.delete();
        end else begin
            if (consumed) void'(mq.pop_front());
            if (accepted) mq.push_back(ref_ext(in_data, in_mode, IN_W, OUT_W, SHIFT));
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] d;
        logic [1:0]  m;
        logic [31:0] e;
    } vec_t;

    vec_t tbl[5];

    initial begin
        bit a;
        bit saw_low;
        int idx;

        tbl[0] = '{16'h8001, 2'd0, 32'hFFFF8001};
        tbl[1] = '{16'h8001, 2'd1, 32'h00008001};
        tbl[2] = '{16'h1234, 2'd2, 32'h12340000};
        tbl[3] = '{16'hFFFF, 2'd3, 32'hFFFFFFFC};
        tbl[4] = '{16'h7FFF, 2'd3, 32'h0001FFFC};

        rst_n = 1'b0;
        flush = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_in_mode = '0; b_out_ready = 1'b1;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        rst_n = 1'b1;
        fresh = 1'b1;
        step(a);
        step(a);

        // Mode table, back-to-back with 1-cycle latency.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = tbl[i].d;
            in_mode  = tbl[i].m;
            step(a);
            check("tbl_valid", out_valid, 1);
            check("tbl_data", out_data, tbl[i].e);
        end
        in_valid = 1'b0;
        step(a);
        step(a);

        // Second parameter set: IN_W=12, OUT_W=20, SHIFT=1.
        check("b_in_ready", b_in_ready, 1);
        b_in_valid = 1'b1; b_in_data = 12'h800; b_in_mode = 2'd3;
        @(posedge clk); @(negedge clk);
        check("b_valid0", b_out_valid, 1);
        check("b_shift", b_out_data, 20'hFF000);
        check("b_shift_ref", b_out_data, ref_ext(64'h800, 3, 12, 20, 1));
        b_in_data = 12'hABC; b_in_mode = 2'd2;
        @(posedge clk); @(negedge clk);
        check("b_upper", b_out_data, 20'hABC00);
        check("b_upper_ref", b_out_data, ref_ext(64'hABC, 2, 12, 20, 1));
        b_in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        check("b_idle", b_out_valid, 0);
        step(a);

        // Backpressure: 1..4 in zero mode, out_ready low on cycles 2-5.
        got.delete();
        saw_low = 1'b0;
        idx = 1;
        for (int c = 0; c < 14; c++) begin
            in_valid  = (idx <= 4);
            in_data   = 16'(idx);
            in_mode   = 2'd1;
            out_ready = !(c >= 2 && c <= 5);
            step(a);
            if (a) idx++;
            if (!in_ready) saw_low = 1'b1;
        end
        in_valid = 1'b0;
        check("bp_in_ready_fell", saw_low, 1);
        check("bp_count", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) check("bp_order", got[i], i + 1);

        // Flush with the skid full and a new input offered.
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 2'd1;
        in_data = 16'h0011; step(a);
        in_data = 16'h0022; step(a);
        check("fl_full", in_ready, 0);
        flush = 1'b1; out_ready = 1'b1; in_data = 16'hAAAA;
        got.delete();
        step(a);
        flush = 1'b0; in_valid = 1'b0;
        check("fl_out_valid", out_valid, 0);
        check("fl_in_ready", in_ready, 1);
        for (int i = 0; i < 3; i++) step(a);
        check("fl_nothing_out", got.size(), 0);

        // Asynchronous reset between edges with the skid full.
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd0;
        in_data = 16'h0055; step(a);
        in_data = 16'h0066; step(a);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("ar_out_valid", out_valid, 0);
        check("ar_out_data", out_data, 0);
        mq.delete();
        fresh = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        step(a);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h8001; in_mode = 2'd0;
        step(a);
        in_valid = 1'b0;
        check("ar_lat_valid", out_valid, 1);
        check("ar_lat_data", out_data, 32'hFFFF8001);
        step(a);

        // Random soak against the queue model.
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_data   = 16'($urandom);
            in_mode   = 2'($urandom_range(3));
            out_ready = ($urandom_range(1) == 1);
            flush     = ($urandom_range(31) == 0);
            step(a);
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step(a);
        step(a);
        step(a);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imm_extend_stage.md
Name: imm_extend_stage

Overview:
- Registered, parametrised immediate-extension stage for the pipelined MIPS datapath, placed between decode and execute.
- Widens an IN_W-bit immediate to OUT_W bits in one of four modes: sign, zero, upper/LUI, or sign-extend-and-shift for branch offsets.
- Uses a valid/ready handshake with a 2-entry skid buffer, so execute-stage stalls never drop or reorder immediates.
- Supports a pipeline flush.

Parameters:
IN_W, 16, immediate input width; 1 <= IN_W < OUT_W
OUT_W, 32, extended output width
SHIFT, 2, left-shift amount applied in mode 3; 0 <= SHIFT < OUT_W
(Any constraint violation is an elaboration-time error.)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous, active-low reset
flush  input  1  synchronous pipeline flush; discards all held and incoming data
in_valid  input  1  in_data/in_mode valid this cycle
in_ready  output  1  stage can accept input this cycle
in_data  input  IN_W  raw immediate field
in_mode  input  2  0 = sign, 1 = zero, 2 = upper, 3 = sign-shift
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  OUT_W  extended immediate

Behaviour:
Reset (rst_n low, asynchronous):
- out_valid = 0, out_data = 0.
- Skid entry empty, skid data = 0.
- in_ready = 1 from the first edge after reset release.

Extension function ext(d, m):
- m=0: {(OUT_W-IN_W){d[IN_W-1]}, d}.
- m=1: {(OUT_W-IN_W){0}, d}.
- m=2: {d, (OUT_W-IN_W){0}}.
- m=3: ext(d,0) << SHIFT, truncated to OUT_W; vacated LSBs are 0.
- Purely combinational ahead of the registers; no other arithmetic.

Storage:
- Main register: out_valid/out_data.
- Skid register: skid_valid/skid_data.
- in_ready = !skid_valid (registered, no combinational path from out_ready).

Per rising edge, evaluated in priority order:
1. flush=1: out_valid <= 0, skid_valid <= 0. Any input offered this cycle is dropped, even if the handshake would accept it. Data registers may hold stale values.
2. Else, let acc = in_valid & in_ready and drain = !out_valid | out_ready.
   - drain & skid_valid: main <= skid; skid_valid <= 0. acc is 0 here, because in_ready is low.
   - drain & !skid_valid & acc: main <= ext(in); out_valid <= 1.
   - drain & !skid_valid & !acc: out_valid <= 0.
   - !drain & acc: skid <= ext(in); skid_valid <= 1. Main holds.
   - !drain & !acc: hold everything.

Guarantees:
- Latency is 1 cycle, input accept to out_valid, when unstalled.
- Throughput is 1 per cycle with out_ready held high.
- Order is strictly FIFO; there is no loss and no duplication.
- While out_valid=1 & out_ready=0, out_data is stable.
- At most 2 items are held. in_ready drops the cycle after the skid fills and rises the cycle after it drains.
- in_mode is sampled only on acceptance; mode changes mid-stall do not affect held data.

Boundary cases:
- A reset asserted mid-stall clears both entries immediately, without waiting for a clock edge.
- flush together with out_ready=1 counts as a flush: the downstream consumes at most the currently shown beat.
- With in_valid held and out_ready toggling, no bubble is inserted beyond the skid refill cycle.

Test Plan:
- Modes, IN_W=16, OUT_W=32, SHIFT=2, out_ready=1, one per cycle:
  - 0x8001/m0 -> 0xFFFF8001
  - 0x8001/m1 -> 0x00008001
  - 0x1234/m2 -> 0x12340000
  - 0xFFFF/m3 -> 0xFFFFFFFC
  - 0x7FFF/m3 -> 0x0001FFFC
  - Each appears exactly 1 cycle after acceptance, back-to-back.
- Backpressure: stream 0x0001..0x0004/m1 with out_ready low for cycles 2-5.
  - in_ready must fall after 2 items are held.
  - On release, the outputs are 1, 2, 3, 4 in order, with no gaps once flowing and out_data stable while stalled.
- Flush: hold 2 items (skid full), then assert flush together with in_valid=1 (0xAAAA).
  - Next cycle: out_valid=0, in_ready=1.
  - 0xAAAA is never output.
- Async reset mid-stall: drop rst_n between clock edges while out_valid=1.
  - out_valid and out_data go to 0 immediately.
  - After release, the first accepted item emerges with 1-cycle latency.
- Parameter sweep, IN_W=12, OUT_W=20, SHIFT=1: 0x800/m3 -> 0xFF000; 0xABC/m2 -> 0xABC00.
- Random soak: random in_valid, out_ready, and flush for 10k cycles against a reference queue model.
  - No loss, duplication, or reordering between flushes.
